alu_result_checker: RTL
=======================

# alu_result_checker

Synthesizable response checker for the 64-bit ALU that forms the other end of the ALU stimulus path. The ALU tester drives operands and opcodes; this block samples each operand/result/flag tuple, recomputes the expected result with an internal reference model, and counts passes and mismatches. It captures the first failure for readout and sits beside the ALU in the execute-stage bench and in on-chip self-test builds.

## Interface
- CNT_W, 16, width of pass, error and index counters
- CHECK_FLAGS, 1, 1 = compare negative/zero/overflow/carry_out; 0 = compare result only
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: clear counters and capture, enter RUN
- stop  in  1  one-cycle pulse: end session after pipeline drains
- obs_valid  in  1  one observation tuple present this cycle
- A, B  in  64  operands applied to the ALU
- SHAMT  in  6  shift amount applied to the ALU
- cntrl  in  3  opcode applied to the ALU
- result  in  64  ALU result
- negative, zero, overflow, carry_out  in  1 each  ALU flags
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE until next start
- pass_count, err_count  out  CNT_W  saturating counters
- first_err_valid  out  1  a mismatch has been captured this session
- first_err_index  out  CNT_W  observation index (0-based) of first mismatch
- first_err_cntrl  out  3  opcode of first mismatch
- first_err_exp, first_err_got  out  64  expected / observed result of first mismatch
- first_err_flags_exp, first_err_flags_got  out  4  {negative, zero, overflow, carry_out}

## Operation
- Opcodes: 000 ADD, 001 SUB (A + ~B + 1), 010 AND, 011 ORR, 100 EOR, 101 LSL (A << SHAMT), 110 LSR (A >> SHAMT, zero-fill), 111 PASSB.
- Expected flags: negative = bit 63, zero = (result == 0). overflow and carry_out come from the 65-bit sum for ADD/SUB and are 0 for all other opcodes. SUB carry_out = 1 means no borrow.
- Mismatch: result differs, or (CHECK_FLAGS=1) any flag differs.
- FSM: IDLE -> RUN on start. RUN -> DRAIN on stop. DRAIN lasts 2 cycles, then DONE. DONE -> RUN on start.
- start in any state clears the counters, the capture registers and the pipeline valids, then enters RUN. start wins over a simultaneous stop.
- obs_valid is accepted only in RUN, including the cycle stop is asserted. It is ignored in IDLE, DRAIN and DONE.
- Each accepted tuple gets an index equal to the count of accepted tuples before it. The index counter saturates at 2^CNT_W-1.
- pass_count and err_count saturate at 2^CNT_W-1 and never wrap.
- Capture registers load only on the first mismatch of a session and hold afterwards.

## Timing
- Stage 1 registers the tuple and index. Stage 2 registers the reference-model output and compare result.
- Counters and capture update on the edge 2 cycles after the accepted obs_valid edge. Back-to-back obs_valid gives throughput of 1 per cycle.
- done rises 3 edges after the stop edge, once the last accepted tuple has been counted.
- Reset (asynchronous, mid-operation included): state IDLE, every output 0, pipeline valids 0. In-flight tuples are discarded.

## Structure
- Shared header alu_defs.vh, used by the ALU and this block: opcode constants, flag bit order {N,Z,V,C}, FSM state encodings.
- Sub-module alu_ref_model: combinational opcode/A/B/SHAMT -> expected result and flags. It is reused by later ALU benches.
- The top level holds the FSM, the 2-stage pipeline, the counters and the capture registers.

## Test plan
- A=4, B=3, SHAMT=8, all 8 opcodes in sequence, correct ALU responses -> pass_count=8, err_count=0. Results 7, 1, 0, 7, 7, 0x400, 0, 3. SUB carry_out=1.
- A=0x7FFF_FFFF_FFFF_FFFF, B=1, ADD, result 0x8000_0000_0000_0000, N=1 V=1 C=0 -> pass. Same tuple with V=0 -> err_count=1, first_err_flags_exp=4'b1010, first_err_flags_got=4'b1000.
- 5 tuples where index 2 has result off by one and index 4 is also wrong -> err_count=2, first_err_index=2, capture not overwritten by index 4.
- obs_valid in IDLE and DONE, simultaneous start+stop -> nothing counted while idle or done. The start+stop cycle leaves the block in RUN with counters 0.
- CNT_W=4, 20 passing tuples -> pass_count=15, first_err_valid=0.
- Reset asserted with 2 tuples in flight -> all outputs 0 immediately. After release and start, the old tuples are never counted.

Source files
------------

// File: rtl/alu_result_checker_pkg.sv
// Shared definitions for the ALU response checker: opcodes, FSM states,
// observation tuple layout and the {N,Z,V,C} flag packing helper.
package alu_result_checker_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_ORR   = 3'b011,
    OP_EOR   = 3'b100,
    OP_LSL   = 3'b101,
    OP_LSR   = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } chk_state_e;

  typedef struct packed {
    logic [2:0]        cntrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [5:0]        shamt;
    logic [DATA_W-1:0] result;
    logic [3:0]        flags;
  } obs_t;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic v, input logic c);
    return {n, z, v, c};
  endfunction

endpackage

// File: rtl/alu_result_checker_if.sv
// Observation bus between the ALU under test and the response checker.
interface alu_result_checker_if;
  logic        obs_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic [5:0]  shamt;
  logic [2:0]  cntrl;
  logic [63:0] result;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;

  modport master (
    output obs_valid, a, b, shamt, cntrl, result,
           negative, zero, overflow, carry_out
  );

  modport slave (
    input obs_valid, a, b, shamt, cntrl, result,
          negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/alu_result_checker_ref_model.sv
// Combinational golden model of the 64-bit ALU: opcode/operands -> result
// and {N,Z,V,C}. Kept standalone so later ALU benches can reuse it.
module alu_ref_model
  import alu_result_checker_pkg::*;
(
  input  logic [2:0]        cntrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [5:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  logic              is_sub;
  logic              is_arith;
  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   sum;
  logic              overflow;
  logic              carry;

  always_comb begin
    is_sub   = (cntrl == OP_SUB);
    is_arith = (cntrl == OP_ADD) || is_sub;
    addend   = is_sub ? ~b : b;
    // SUB is A + ~B + 1, so carry out of the 65-bit sum means "no borrow"
    sum      = {1'b0, a} + {1'b0, addend} + {{DATA_W{1'b0}}, is_sub};

    result = '0;
    unique case (alu_op_e'(cntrl))
      OP_ADD, OP_SUB: result = sum[DATA_W-1:0];
      OP_AND:         result = a & b;
      OP_ORR:         result = a | b;
      OP_EOR:         result = a ^ b;
      OP_LSL:         result = a << shamt;
      OP_LSR:         result = a >> shamt;
      default:        result = b;
    endcase

    overflow = is_arith && (a[DATA_W-1] == addend[DATA_W-1]) &&
               (sum[DATA_W-1] != a[DATA_W-1]);
    carry    = is_arith && sum[DATA_W];
    flags    = pack_flags(result[DATA_W-1], result == '0, overflow, carry);
  end

endmodule

// File: rtl/alu_result_checker.sv
// ALU response checker: two-stage compare pipeline against alu_ref_model,
// saturating pass/error counters and first-failure capture, under a session FSM.
module alu_result_checker
  import alu_result_checker_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit CHECK_FLAGS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  alu_result_checker_if.slave  obs,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     err_count,
  output logic                 first_err_valid,
  output logic [CNT_W-1:0]     first_err_index,
  output logic [2:0]           first_err_cntrl,
  output logic [DATA_W-1:0]    first_err_exp,
  output logic [DATA_W-1:0]    first_err_got,
  output logic [3:0]           first_err_flags_exp,
  output logic [3:0]           first_err_flags_got
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  chk_state_e        state_q, state_d;
  logic              drain_last_q, drain_last_d;
  logic [CNT_W-1:0]  idx_q, idx_d;

  logic              s1_valid_q, s1_valid_d;
  obs_t              s1_obs_q, s1_obs_d;
  logic [CNT_W-1:0]  s1_idx_q, s1_idx_d;

  logic              s2_valid_q, s2_valid_d;
  logic              s2_mismatch_q, s2_mismatch_d;
  logic [CNT_W-1:0]  s2_idx_q, s2_idx_d;
  logic [2:0]        s2_cntrl_q, s2_cntrl_d;
  logic [DATA_W-1:0] s2_exp_q, s2_exp_d;
  logic [DATA_W-1:0] s2_got_q, s2_got_d;
  logic [3:0]        s2_fexp_q, s2_fexp_d;
  logic [3:0]        s2_fgot_q, s2_fgot_d;

  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              fv_q, fv_d;
  logic [CNT_W-1:0]  fidx_q, fidx_d;
  logic [2:0]        fcntrl_q, fcntrl_d;
  logic [DATA_W-1:0] fexp_q, fexp_d;
  logic [DATA_W-1:0] fgot_q, fgot_d;
  logic [3:0]        ffexp_q, ffexp_d;
  logic [3:0]        ffgot_q, ffgot_d;

  logic              accept;
  logic [DATA_W-1:0] ref_result;
  logic [3:0]        ref_flags;

  alu_ref_model u_ref (
    .cntrl  (s1_obs_q.cntrl),
    .a      (s1_obs_q.a),
    .b      (s1_obs_q.b),
    .shamt  (s1_obs_q.shamt),
    .result (ref_result),
    .flags  (ref_flags)
  );

  always_comb begin
    state_d      = state_q;
    drain_last_d = drain_last_q;
    unique case (state_q)
      ST_RUN: begin
        if (stop) begin
          state_d      = ST_DRAIN;
          drain_last_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_last_q) state_d = ST_DONE;
        else              drain_last_d = 1'b1;
      end
      default: ;
    endcase
    if (start) state_d = ST_RUN;
  end

  // A tuple arriving together with start belongs to no session and is dropped
  assign accept = (state_q == ST_RUN) && obs.obs_valid && !start;

  always_comb begin
    s1_valid_d = accept;
    s1_obs_d   = s1_obs_q;
    s1_idx_d   = s1_idx_q;
    idx_d      = idx_q;
    if (accept) begin
      s1_obs_d.cntrl  = obs.cntrl;
      s1_obs_d.a      = obs.a;
      s1_obs_d.b      = obs.b;
      s1_obs_d.shamt  = obs.shamt;
      s1_obs_d.result = obs.result;
      s1_obs_d.flags  = pack_flags(obs.negative, obs.zero, obs.overflow, obs.carry_out);
      s1_idx_d        = idx_q;
      if (idx_q != CNT_MAX) idx_d = idx_q + CNT_ONE;
    end

    s2_valid_d    = s1_valid_q;
    s2_idx_d      = s1_idx_q;
    s2_cntrl_d    = s1_obs_q.cntrl;
    s2_exp_d      = ref_result;
    s2_got_d      = s1_obs_q.result;
    s2_fexp_d     = ref_flags;
    s2_fgot_d     = s1_obs_q.flags;
    s2_mismatch_d = (ref_result != s1_obs_q.result) ||
                    (CHECK_FLAGS && (ref_flags != s1_obs_q.flags));

    pass_d   = pass_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fidx_d   = fidx_q;
    fcntrl_d = fcntrl_q;
    fexp_d   = fexp_q;
    fgot_d   = fgot_q;
    ffexp_d  = ffexp_q;
    ffgot_d  = ffgot_q;
    if (s2_valid_q) begin
      if (s2_mismatch_q) begin
        if (err_q != CNT_MAX) err_d = err_q + CNT_ONE;
        if (!fv_q) begin
          fv_d     = 1'b1;
          fidx_d   = s2_idx_q;
          fcntrl_d = s2_cntrl_q;
          fexp_d   = s2_exp_q;
          fgot_d   = s2_got_q;
          ffexp_d  = s2_fexp_q;
          ffgot_d  = s2_fgot_q;
        end
      end else if (pass_q != CNT_MAX) begin
        pass_d = pass_q + CNT_ONE;
      end
    end

    if (start) begin
      idx_d      = '0;
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      pass_d     = '0;
      err_d      = '0;
      fv_d       = 1'b0;
      fidx_d     = '0;
      fcntrl_d   = '0;
      fexp_d     = '0;
      fgot_d     = '0;
      ffexp_d    = '0;
      ffgot_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      drain_last_q  <= 1'b0;
      idx_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_obs_q      <= '0;
      s1_idx_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_mismatch_q <= 1'b0;
      s2_idx_q      <= '0;
      s2_cntrl_q    <= '0;
      s2_exp_q      <= '0;
      s2_got_q      <= '0;
      s2_fexp_q     <= '0;
      s2_fgot_q     <= '0;
      pass_q        <= '0;
      err_q         <= '0;
      fv_q          <= 1'b0;
      fidx_q        <= '0;
      fcntrl_q      <= '0;
      fexp_q        <= '0;
      fgot_q        <= '0;
      ffexp_q       <= '0;
      ffgot_q       <= '0;
    end else begin
      state_q       <= state_d;
      drain_last_q  <= drain_last_d;
      idx_q         <= idx_d;
      s1_valid_q    <= s1_valid_d;
      s1_obs_q      <= s1_obs_d;
      s1_idx_q      <= s1_idx_d;
      s2_valid_q    <= s2_valid_d;
      s2_mismatch_q <= s2_mismatch_d;
      s2_idx_q      <= s2_idx_d;
      s2_cntrl_q    <= s2_cntrl_d;
      s2_exp_q      <= s2_exp_d;
      s2_got_q      <= s2_got_d;
      s2_fexp_q     <= s2_fexp_d;
      s2_fgot_q     <= s2_fgot_d;
      pass_q        <= pass_d;
      err_q         <= err_d;
      fv_q          <= fv_d;
      fidx_q        <= fidx_d;
      fcntrl_q      <= fcntrl_d;
      fexp_q        <= fexp_d;
      fgot_q        <= fgot_d;
      ffexp_q       <= ffexp_d;
      ffgot_q       <= ffgot_d;
    end
  end

  assign busy                = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done                = (state_q == ST_DONE);
  assign pass_count          = pass_q;
  assign err_count           = err_q;
  assign first_err_valid     = fv_q;
  assign first_err_index     = fidx_q;
  assign first_err_cntrl     = fcntrl_q;
  assign first_err_exp       = fexp_q;
  assign first_err_got       = fgot_q;
  assign first_err_flags_exp = ffexp_q;
  assign first_err_flags_got = ffgot_q;

endmodule
